// File: rtl/mips_pkg.sv
// Shared definitions for the R-type sequencer: opcode/func codes, reject causes
// and the controller state type.
package mips_pkg;

    localparam logic [5:0] R_TYPE    = 6'h00;

    localparam logic [5:0] FUNC_SLL  = 6'h00;
    localparam logic [5:0] FUNC_SRL  = 6'h02;
    localparam logic [5:0] FUNC_SRA  = 6'h03;
    localparam logic [5:0] FUNC_ADD  = 6'h20;
    localparam logic [5:0] FUNC_ADDU = 6'h21;
    localparam logic [5:0] FUNC_SUB  = 6'h22;
    localparam logic [5:0] FUNC_AND  = 6'h24;
    localparam logic [5:0] FUNC_OR   = 6'h25;
    localparam logic [5:0] FUNC_SLTU = 6'h2B;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_OPCODE = 2'b01;
    localparam logic [1:0] ERR_FUNC   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_READ,
        ST_EXEC,
        ST_WRITE,
        ST_ERR
    } seq_state_t;

    function automatic logic func_supported(input logic [5:0] func);
        case (func)
            FUNC_SLL, FUNC_SRL, FUNC_SRA, FUNC_ADD, FUNC_ADDU,
            FUNC_SUB, FUNC_AND, FUNC_OR, FUNC_SLTU: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_rtype_decode.sv
// Combinational R-type field split plus legality check of the latched
// instruction word.
module mips_rtype_decode
    import mips_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  func,
    output logic        legal,
    output logic [1:0]  err_code
);

    always_comb begin
        rs       = instr[25:21];
        rt       = instr[20:16];
        rd       = instr[15:11];
        shamt    = instr[10:6];
        func     = instr[5:0];
        legal    = 1'b0;
        err_code = ERR_NONE;
        if (instr[31:26] != R_TYPE) begin
            err_code = ERR_OPCODE;
        end else if (!func_supported(instr[5:0])) begin
            err_code = ERR_FUNC;
        end else begin
            legal = 1'b1;
        end
    end

endmodule

// File: rtl/mips_rtype_sequencer.sv
// Multi-cycle R-type controller: IDLE -> DECODE -> READ -> EXEC -> WRITE (or ERR).
// Define MIPS_SEQ_PERF_CNT_EN to add the retired/rejected performance counters.
module mips_rtype_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    output logic [4:0]        rf_rs_addr,
    output logic [4:0]        rf_rt_addr,
    input  logic [31:0]       rs_data,
    input  logic [31:0]       rt_data,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [5:0]        alu_func,
    output logic [4:0]        alu_shamt,
    input  logic [31:0]       alu_result,
    output logic              rf_wr_en,
    output logic [4:0]        rf_wr_addr,
    output logic [31:0]       rf_wr_data,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
`ifdef MIPS_SEQ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  retired_cnt,
    output logic [CNT_W-1:0]  rejected_cnt
`endif
);

    seq_state_t  state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [31:0] result_q, result_d;

    logic [4:0]  dec_rs, dec_rt, dec_rd, dec_shamt;
    logic [5:0]  dec_func;
    logic        dec_legal;
    logic [1:0]  dec_err_code;

    mips_rtype_decode u_decode (
        .instr    (instr_q),
        .rs       (dec_rs),
        .rt       (dec_rt),
        .rd       (dec_rd),
        .shamt    (dec_shamt),
        .func     (dec_func),
        .legal    (dec_legal),
        .err_code (dec_err_code)
    );

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = dec_legal ? ST_READ : ST_ERR;
            ST_READ: begin
                op_a_d  = rs_data;
                op_b_d  = rt_data;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                result_d = alu_result;
                state_d  = ST_WRITE;
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are forced low while rst is asserted so an instruction caught
    // mid-flight can neither write nor pulse done/err.
    always_comb begin
        instr_ready = 1'b0;
        rf_rs_addr  = '0;
        rf_rt_addr  = '0;
        alu_a       = '0;
        alu_b       = '0;
        alu_func    = '0;
        alu_shamt   = '0;
        rf_wr_en    = 1'b0;
        rf_wr_addr  = '0;
        rf_wr_data  = '0;
        done        = 1'b0;
        err         = 1'b0;
        err_code    = '0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: instr_ready = 1'b1;
                ST_READ, ST_EXEC, ST_WRITE: begin
                    rf_rs_addr = dec_rs;
                    rf_rt_addr = dec_rt;
                    alu_func   = dec_func;
                    alu_shamt  = dec_shamt;
                    if (state_q != ST_READ) begin
                        alu_a = op_a_q;
                        alu_b = op_b_q;
                    end
                    if (state_q == ST_WRITE) begin
                        rf_wr_addr = dec_rd;
                        rf_wr_data = result_q;
                        rf_wr_en   = (dec_rd != 5'd0);
                        done       = 1'b1;
                    end
                end
                ST_ERR: begin
                    err      = 1'b1;
                    err_code = dec_err_code;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            instr_q  <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
        end
    end

`ifdef MIPS_SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] rejected_q, rejected_d;

    always_comb begin
        retired_d  = retired_q + CNT_W'(done);
        rejected_d = rejected_q + CNT_W'(err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q  <= '0;
            rejected_q <= '0;
        end else begin
            retired_q  <= retired_d;
            rejected_q <= rejected_d;
        end
    end

    assign retired_cnt  = retired_q;
    assign rejected_cnt = rejected_q;
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_mips_rtype_sequencer.sv
// Self-checking bench for mips_rtype_sequencer: register file and ALU models,
// directed vector table, reset/back-to-back sequences and randomized traffic.
module tb_mips_rtype_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [4:0]  rf_rs_addr, rf_rt_addr;
    logic [31:0] rs_data, rt_data;
    logic [31:0] alu_a, alu_b;
    logic [5:0]  alu_func;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_result;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic        done, err;
    logic [1:0]  err_code;
`ifdef MIPS_SEQ_PERF_CNT_EN
    logic [31:0] retired_cnt, rejected_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int exp_retired = 0;
    int exp_rejected = 0;

    always #5 clk = ~clk;

    mips_rtype_sequencer #(.CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .rf_rs_addr  (rf_rs_addr),
        .rf_rt_addr  (rf_rt_addr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_func    (alu_func),
        .alu_shamt   (alu_shamt),
        .alu_result  (alu_result),
        .rf_wr_en    (rf_wr_en),
        .rf_wr_addr  (rf_wr_addr),
        .rf_wr_data  (rf_wr_data),
        .done        (done),
        .err         (err),
        .err_code    (err_code)
`ifdef MIPS_SEQ_PERF_CNT_EN
        ,
        .retired_cnt (retired_cnt),
        .rejected_cnt(rejected_cnt)
`endif
    );

    // Register file model ($0 never written) and expected architectural state.
    logic [31:0] regs [32];
    logic [31:0] gold [32];
    logic        rf_clr, tb_wr_en;
    logic [4:0]  tb_wr_addr;
    logic [31:0] tb_wr_data;

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (tb_wr_en) begin
            regs[tb_wr_addr] <= tb_wr_data;
        end else if (rf_wr_en && rf_wr_addr != 5'd0) begin
            regs[rf_wr_addr] <= rf_wr_data;
        end
    end

    assign rs_data = regs[rf_rs_addr];
    assign rt_data = regs[rf_rt_addr];

    function automatic logic [31:0] alu_ref(input logic [5:0] fn, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        case (fn)
            6'h20, 6'h21: return a + b;
            6'h22:        return a - b;
            6'h24:        return a & b;
            6'h25:        return a | b;
            6'h00:        return b << sh;
            6'h02:        return b >> sh;
            6'h03:        return $signed(b) >>> sh;
            6'h2B:        return (a < b) ? 32'd1 : 32'd0;
            default:      return 32'd0;
        endcase
    endfunction

    assign alu_result = alu_ref(alu_func, alu_a, alu_b, alu_shamt);

    logic [5:0] ok_funcs [9] = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h00, 6'h02, 6'h03, 6'h2B};

    function automatic void ref_decode(input logic [31:0] iw, output logic e, output logic [1:0] c);
        logic found = 1'b0;
        for (int i = 0; i < 9; i++) if (iw[5:0] == ok_funcs[i]) found = 1'b1;
        if (iw[31:26] != 6'd0) begin e = 1'b1; c = 2'b01; end
        else if (!found)       begin e = 1'b1; c = 2'b10; end
        else                   begin e = 1'b0; c = 2'b00; end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        tb_wr_en   = 1'b1;
        tb_wr_addr = a;
        tb_wr_data = d;
        step();
        tb_wr_en   = 1'b0;
        gold[a]    = d;
    endtask

    // Called in an IDLE cycle (cycle 0); returns in the cycle ready is expected again.
    task automatic run_instr(input logic [31:0] iw, input logic e_err, input logic [1:0] e_code,
                             input logic e_wr, input logic [31:0] e_data, input bit keep);
        logic [4:0] rs, rt, rd, sh;
        logic [5:0] fn;
        rs = iw[25:21]; rt = iw[20:16]; rd = iw[15:11]; sh = iw[10:6]; fn = iw[5:0];
        instr_valid = 1'b1;
        instr       = iw;
        chk("ready_c0", instr_ready, 1);
        chk("done_c0", done, 0);
        step();
        instr = $urandom;
        instr_valid = keep;
        chk("ready_c1", instr_ready, 0);
        chk("done_c1", done, 0);
        chk("err_c1", err, 0);
        chk("wren_c1", rf_wr_en, 0);
        step();
        if (e_err) begin
            chk("err_c2", err, 1);
            chk("errcode_c2", err_code, e_code);
            chk("done_c2", done, 0);
            chk("wren_c2", rf_wr_en, 0);
            chk("rsaddr_err", rf_rs_addr, 0);
            chk("alua_err", alu_a, 0);
            step();
            chk("ready_c3", instr_ready, 1);
            chk("err_c3", err, 0);
            chk("wren_c3", rf_wr_en, 0);
            exp_rejected++;
        end else begin
            chk("rsaddr_c2", rf_rs_addr, rs);
            chk("rtaddr_c2", rf_rt_addr, rt);
            chk("err_c2", err, 0);
            chk("done_c2", done, 0);
            step();
            chk("alua_c3", alu_a, gold[rs]);
            chk("alub_c3", alu_b, gold[rt]);
            chk("alufunc_c3", alu_func, fn);
            chk("alushamt_c3", alu_shamt, sh);
            chk("rsaddr_c3", rf_rs_addr, rs);
            chk("wren_c3", rf_wr_en, 0);
            step();
            chk("wren_c4", rf_wr_en, e_wr);
            chk("wraddr_c4", rf_wr_addr, rd);
            chk("wrdata_c4", rf_wr_data, e_data);
            chk("done_c4", done, 1);
            chk("err_c4", err, 0);
            chk("alua_c4", alu_a, gold[rs]);
            chk("rtaddr_c4", rf_rt_addr, rt);
            step();
            chk("ready_c5", instr_ready, 1);
            chk("done_c5", done, 0);
            if (e_wr) gold[rd] = e_data;
            chk("regfile", regs[rd], gold[rd]);
            exp_retired++;
        end
    endtask

    typedef struct {
        logic [31:0] iw;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic        e_err;
        logic [1:0]  e_code;
        logic        e_wr;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic [31:0] iw, ed;
        logic        ee;
        logic [1:0]  ec;
        int unsigned r;

        tbl[0] = '{32'h00221820, 32'd5, 32'd7, 1'b0, 2'b00, 1'b1, 32'd12};         // ADD $3,$1,$2
        tbl[1] = '{32'h00022103, 32'd0, 32'h80000000, 1'b0, 2'b00, 1'b1, 32'hF8000000}; // SRA $4,$2,4
        tbl[2] = '{32'h20010005, 32'd0, 32'd0, 1'b1, 2'b01, 1'b0, 32'd0};          // opcode 0x08
        tbl[3] = '{32'h00221827, 32'd5, 32'd7, 1'b1, 2'b10, 1'b0, 32'd0};          // func 0x27
        tbl[4] = '{32'h00220020, 32'd5, 32'd7, 1'b0, 2'b00, 1'b0, 32'd12};         // ADD $0,$1,$2
        tbl[5] = '{32'h00000000, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0, 32'd0};          // NOP
        tbl[6] = '{32'h00222822, 32'd5, 32'd7, 1'b0, 2'b00, 1'b1, 32'hFFFFFFFE};   // SUB $5,$1,$2
        tbl[7] = '{32'h0022302B, 32'd5, 32'd7, 1'b0, 2'b00, 1'b1, 32'd1};          // SLTU $6,$1,$2
        tbl[8] = '{32'h00024A02, 32'd0, 32'h80000000, 1'b0, 2'b00, 1'b1, 32'h00800000}; // SRL $9,$2,8
        tbl[9] = '{32'h00223024, 32'hF0F0FF00, 32'h0FF0F0F0, 1'b0, 2'b00, 1'b1, 32'h00F0F000}; // AND $6

        rst = 1'b1; instr_valid = 1'b0; instr = '0;
        rf_clr = 1'b1; tb_wr_en = 1'b0; tb_wr_addr = '0; tb_wr_data = '0;
        for (int i = 0; i < 32; i++) gold[i] = '0;
        step();
        step();
        chk("rst_ready", instr_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_wren", rf_wr_en, 0);
        chk("rst_rsaddr", rf_rs_addr, 0);
        chk("rst_alua", alu_a, 0);
        chk("rst_wrdata", rf_wr_data, 0);
        rf_clr = 1'b0;
        rst = 1'b0;
        #1;
        chk("ready_after_rst", instr_ready, 1);

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].iw[25:21] != 5'd0) preload(tbl[i].iw[25:21], tbl[i].rs_val);
            if (tbl[i].iw[20:16] != 5'd0) preload(tbl[i].iw[20:16], tbl[i].rt_val);
            run_instr(tbl[i].iw, tbl[i].e_err, tbl[i].e_code, tbl[i].e_wr, tbl[i].e_data, 1'b0);
        end

        // Reset during cycle 2 of an ADD: no write, no done, ready right after.
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd7);
        preload(5'd3, 32'h0000DEAD);
        instr_valid = 1'b1;
        instr = 32'h00221820;
        step();
        instr_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("midrst_ready", instr_ready, 0);
        chk("midrst_rsaddr", rf_rs_addr, 0);
        chk("midrst_done", done, 0);
        step();
        rst = 1'b0;
        exp_retired = 0;
        exp_rejected = 0;
        #1;
        chk("midrst_ready_after", instr_ready, 1);
        for (int i = 0; i < 6; i++) begin
            chk("midrst_wren", rf_wr_en, 0);
            chk("midrst_done_after", done, 0);
            step();
        end
        chk("midrst_reg3", regs[3], 32'h0000DEAD);

        // Valid held across two ADDs: acceptance at cycles 0 and 5.
        run_instr(32'h00223820, 1'b0, 2'b00, 1'b1, 32'd12, 1'b1);   // ADD $7,$1,$2
        run_instr(32'h00E14020, 1'b0, 2'b00, 1'b1, 32'd17, 1'b0);   // ADD $8,$7,$1
`ifdef MIPS_SEQ_PERF_CNT_EN
        chk("retired_b2b", retired_cnt, 32'd2);
        chk("rejected_b2b", rejected_cnt, 32'd0);
`endif

        for (int i = 1; i < 32; i++) preload(5'(i), $urandom);
        for (int n = 0; n < 40; n++) begin
            r  = $urandom_range(0, 9);
            iw = $urandom;
            if (r == 0) begin
                iw[31:26] = 6'($urandom_range(1, 63));
            end else begin
                iw[31:26] = 6'd0;
                if (r != 1) iw[5:0] = ok_funcs[$urandom_range(0, 8)];
            end
            ref_decode(iw, ee, ec);
            ed = alu_ref(iw[5:0], gold[iw[25:21]], gold[iw[20:16]], iw[10:6]);
            run_instr(iw, ee, ec, !ee && (iw[15:11] != 5'd0), ed, 1'b0);
        end
`ifdef MIPS_SEQ_PERF_CNT_EN
        chk("retired_final", retired_cnt, exp_retired);
        chk("rejected_final", rejected_cnt, exp_rejected);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
